// File: rtl/throw_charge_ctl.sv
// throw_charge_ctl: fire-button charge meter feeding the throw controllers.
// Holding the button makes the meter ping-pong between 0 and FORCE_MAX.
// Releasing it latches the meter as throw_force, and throw_en then stays
// high until the controller returns throw_done.
// Optional feature: define THROW_WIND_RANDOM_EN to draw a per-turn wind value
// from an LFSR. When it is undefined, wind_force is a constant 50 (calm).
module throw_charge_ctl #(
  parameter int TICK_DIV   = 1300000,
  parameter int FORCE_STEP = 16,
  parameter int FORCE_MAX  = 1023,
  parameter int MIN_FORCE  = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       turn_en,
  input  logic       btn,
  input  logic       throw_done,
  output logic       throw_en,
  output logic [9:0] throw_force,
  output logic [6:0] wind_force,
  output logic [9:0] force_level,
  output logic       charging,
  output logic       turn_done
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);
  localparam logic [10:0]   STEP11    = 11'(FORCE_STEP);
  localparam logic [10:0]   MAX11     = 11'(FORCE_MAX);
  localparam logic [9:0]    MAX10     = 10'(FORCE_MAX);
  localparam logic [9:0]    MIN10     = 10'(MIN_FORCE);

  typedef enum logic [1:0] {IDLE, CHARGE, THROW} state_t;

  state_t        state, state_nx;
  logic          btn_m, btn_s, btn_s_d;
  logic          press, tick, dir_dn;
  logic [CW-1:0] cnt;
  logic [10:0]   sum_up;
  logic [9:0]    lvl_up, lvl_dn;

  // The button is asynchronous: two flops bring it into clk, and a third
  // flop gives the previous value for rising-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_m   <= 1'b0;
      btn_s   <= 1'b0;
      btn_s_d <= 1'b0;
    end else begin
      btn_m   <= btn;
      btn_s   <= btn_m;
      btn_s_d <= btn_s;
    end
  end

  assign press = btn_s & ~btn_s_d;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next state. In CHARGE, losing the turn takes priority over a release,
  // so an abort never launches a throw.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (turn_en && press) state_nx = CHARGE;
      CHARGE:  if (!turn_en)         state_nx = IDLE;
               else if (!btn_s)      state_nx = THROW;
      THROW:   if (throw_done)       state_nx = IDLE;
      default:                       state_nx = IDLE;
    endcase
  end

  // FSM outputs. They decode the state directly, so an async reset drops
  // throw_en at once.
  always_comb begin
    charging = (state == CHARGE);
    throw_en = (state == THROW);
  end

  // Meter tick divider. It is held at 0 outside CHARGE, so each charge
  // starts a full TICK_DIV period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  cnt <= '0;
    else if (state != CHARGE)    cnt <= '0;
    else if (tick)               cnt <= '0;
    else                         cnt <= cnt + 1'b1;
  end

  assign tick = (state == CHARGE) && (cnt == TICK_LAST);

  // Candidate next meter values. The math is 11 bits wide so that neither
  // direction can wrap.
  always_comb begin
    sum_up = {1'b0, force_level} + STEP11;
    lvl_up = (sum_up >= MAX11) ? MAX10 : sum_up[9:0];
    lvl_dn = ({1'b0, force_level} <= STEP11) ? 10'd0
                                             : force_level - STEP11[9:0];
  end

  // Ping-pong meter. It reads 0 whenever the FSM is in IDLE and holds its
  // value through THROW.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      force_level <= '0;
      dir_dn      <= 1'b0;
    end else if (state_nx == IDLE) begin
      force_level <= '0;
      dir_dn      <= 1'b0;
    end else if (state == CHARGE && state_nx == CHARGE && tick) begin
      if (!dir_dn) begin
        force_level <= lvl_up;
        if (sum_up >= MAX11) dir_dn <= 1'b1;
      end else begin
        force_level <= lvl_dn;
        if ({1'b0, force_level} <= STEP11) dir_dn <= 1'b0;
      end
    end
  end

  // Latch the throw force on a release that is not also an abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      throw_force <= '0;
    else if (state == CHARGE && turn_en && !btn_s)
      throw_force <= (force_level < MIN10) ? MIN10 : force_level;
  end

  // Completion pulse. It is high in the same cycle in which throw_en falls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) turn_done <= 1'b0;
    else        turn_done <= (state == THROW) && throw_done;
  end

`ifdef THROW_WIND_RANDOM_EN
  logic [15:0] lfsr;
  logic [6:0]  r;

  assign r = lfsr[6:0];

  // Free-running Galois LFSR. The wind is redrawn as each throw completes,
  // and 101..127 fold down into 74..100.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr       <= 16'hACE1;
      wind_force <= 7'd50;
    end else begin
      lfsr <= lfsr[0] ? ((lfsr >> 1) ^ 16'hB400) : (lfsr >> 1);
      if (state == THROW && throw_done)
        wind_force <= (r > 7'd100) ? r - 7'd27 : r;
    end
  end
`else
  assign wind_force = 7'd50;
`endif

endmodule

// File: tb/tb_throw_charge_ctl.sv
// Directed bench for throw_charge_ctl. One instance uses STEP=16, DIV=4 and
// runs the main table. A second instance uses STEP=300, DIV=2 to exercise
// the ping-pong turnaround.
module tb_throw_charge_ctl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       te, btn, done;
  logic       te_b, btn_b, done_b;
  logic       en, chg, td, en_b, chg_b, td_b;
  logic [9:0] tf, lvl, tf_b, lvl_b;
  logic [6:0] wind, wind_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  throw_charge_ctl #(.TICK_DIV(4), .FORCE_STEP(16), .FORCE_MAX(1023), .MIN_FORCE(64)) dut (
    .clk(clk), .rst_n(rst_n), .turn_en(te), .btn(btn), .throw_done(done),
    .throw_en(en), .throw_force(tf), .wind_force(wind), .force_level(lvl),
    .charging(chg), .turn_done(td));

  throw_charge_ctl #(.TICK_DIV(2), .FORCE_STEP(300), .FORCE_MAX(1023), .MIN_FORCE(64)) dut_b (
    .clk(clk), .rst_n(rst_n), .turn_en(te_b), .btn(btn_b), .throw_done(done_b),
    .throw_en(en_b), .throw_force(tf_b), .wind_force(wind_b), .force_level(lvl_b),
    .charging(chg_b), .turn_done(td_b));

  typedef struct {
    int n;                 // cycles to run with these inputs
    bit te, b, d;          // turn_en, btn, throw_done
    bit x_en, x_chg, x_td; // expected throw_en, charging, turn_done
    int x_lvl, x_tf;       // expected force_level, throw_force
  } vec_t;

  vec_t v[$];

  function automatic vec_t mk(int n, bit t, bit b, bit d, bit e, bit c, int l, int f, bit tdn);
    vec_t r;
    r.n = n; r.te = t; r.b = b; r.d = d;
    r.x_en = e; r.x_chg = c; r.x_lvl = l; r.x_tf = f; r.x_td = tdn;
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  task automatic chk_wind(input string name, input int w);
`ifdef THROW_WIND_RANDOM_EN
    chk(name, (w <= 100) ? 1 : 0, 1);
`else
    chk(name, w, 50);
`endif
  endtask

  initial begin
    rst_n = 1'b0;
    te = 0; btn = 0; done = 0;
    te_b = 0; btn_b = 0; done_b = 0;

    // Table: each row applies the inputs for n cycles, then checks outputs.
    //           n  te b  d  en chg lvl tf  td
    // basic ramp: 5 ticks of 16 give 80
    v.push_back(mk(1,  1, 0, 0, 0, 0,  0,  0, 0));
    v.push_back(mk(2,  1, 1, 0, 0, 0,  0,  0, 0));
    v.push_back(mk(1,  1, 1, 0, 0, 1,  0,  0, 0));
    v.push_back(mk(4,  1, 1, 0, 0, 1, 16,  0, 0));
    v.push_back(mk(16, 1, 1, 0, 0, 1, 80,  0, 0));
    v.push_back(mk(2,  1, 0, 0, 0, 1, 80,  0, 0));
    v.push_back(mk(1,  1, 0, 0, 1, 0, 80, 80, 0));
    // THROW ignores button toggles and a turn_en drop
    v.push_back(mk(5,  1, 1, 0, 1, 0, 80, 80, 0));
    v.push_back(mk(3,  1, 0, 0, 1, 0, 80, 80, 0));
    v.push_back(mk(2,  0, 0, 0, 1, 0, 80, 80, 0));
    // handshake: a one-cycle turn_done
    v.push_back(mk(1,  1, 0, 1, 0, 0,  0, 80, 1));
    v.push_back(mk(1,  1, 0, 0, 0, 0,  0, 80, 0));
    // release before the first tick gives the MIN_FORCE floor
    v.push_back(mk(3,  1, 1, 0, 0, 1,  0, 80, 0));
    v.push_back(mk(3,  1, 0, 0, 1, 0,  0, 64, 0));
    v.push_back(mk(1,  1, 0, 1, 0, 0,  0, 64, 1));
    v.push_back(mk(1,  1, 0, 0, 0, 0,  0, 64, 0));
    // abort at 48, then a held button must not restart the charge
    v.push_back(mk(3,  1, 1, 0, 0, 1,  0, 64, 0));
    v.push_back(mk(12, 1, 1, 0, 0, 1, 48, 64, 0));
    v.push_back(mk(1,  0, 1, 0, 0, 0,  0, 64, 0));
    v.push_back(mk(4,  0, 1, 0, 0, 0,  0, 64, 0));
    v.push_back(mk(10, 1, 1, 0, 0, 0,  0, 64, 0));
    v.push_back(mk(3,  1, 0, 0, 0, 0,  0, 64, 0));
    v.push_back(mk(3,  1, 1, 0, 0, 1,  0, 64, 0));
    // release and turn_en drop land in the same cycle: the abort wins
    v.push_back(mk(2,  1, 0, 0, 0, 1,  0, 64, 0));
    v.push_back(mk(1,  0, 0, 0, 0, 0,  0, 64, 0));
    v.push_back(mk(3,  1, 0, 0, 0, 0,  0, 64, 0));

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_en", en, 0);
    chk("rst_chg", chg, 0);
    chk("rst_lvl", lvl, 0);
    chk("rst_tf", tf, 0);
    chk("rst_td", td, 0);
    chk("rst_wind", wind, 50);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (v[i]) begin
      te = v[i].te; btn = v[i].b; done = v[i].d;
      repeat (v[i].n) @(negedge clk);
      chk($sformatf("v%0d_en", i),  en,  v[i].x_en);
      chk($sformatf("v%0d_chg", i), chg, v[i].x_chg);
      chk($sformatf("v%0d_lvl", i), lvl, v[i].x_lvl);
      chk($sformatf("v%0d_tf", i),  tf,  v[i].x_tf);
      chk($sformatf("v%0d_td", i),  td,  v[i].x_td);
      chk_wind($sformatf("v%0d_wind", i), wind);
    end

    // ping-pong with STEP=300: the meter turns around at 1023
    begin
      int exp_pp[6] = '{300, 600, 900, 1023, 723, 423};
      te_b = 1; btn_b = 1;
      repeat (3) @(negedge clk);
      chk("pp_chg", chg_b, 1);
      for (int k = 0; k < 6; k++) begin
        repeat (2) @(negedge clk);
        chk($sformatf("pp_lvl%0d", k), lvl_b, exp_pp[k]);
      end
      // one more down step lands during the sync delay: 423-300
      btn_b = 0;
      repeat (3) @(negedge clk);
      chk("pp_en", en_b, 1);
      chk("pp_tf", tf_b, 123);
      done_b = 1;
      @(negedge clk);
      done_b = 0;
      chk("pp_td", td_b, 1);
      chk("pp_en_off", en_b, 0);
    end

    // async reset in THROW clears outputs with no clock edge
    te = 1; btn = 1; done = 0;
    repeat (7) @(negedge clk);
    btn = 0;
    repeat (3) @(negedge clk);
    chk("ar_pre_en", en, 1);
    chk("ar_pre_lvl", lvl, 16);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_en", en, 0);
    chk("ar_tf", tf, 0);
    chk("ar_lvl", lvl, 0);
    chk("ar_wind", wind, 50);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/throw_charge_ctl.md
# throw_charge_ctl

Player throw-input stage placed directly upstream of the dog/cat throw controllers. Turns a held fire button into a ping-pong charge meter, latches the meter value as `throw_force` on release, and holds the controller's `enable` until that controller reports `throw_done`. It also supplies the per-turn `wind_force` and exposes the live meter level to the HUD renderer.

## Interface
Parameters:
- `TICK_DIV`, 1300000: clock cycles per meter step; sim uses small values.
- `FORCE_STEP`, 16: meter increment/decrement per tick.
- `FORCE_MAX`, 1023: meter ceiling; must fit in 10 bits.
- `MIN_FORCE`, 64: floor applied to the latched force.

Ports:
- `clk`  in  1: system clock.
- `rst_n`  in  1: reset. **One clock; reset is asynchronous and active-low.**
- `turn_en`  in  1: it is this player's turn.
- `btn`  in  1: raw fire button, asynchronous, active-high.
- `throw_done`  in  1: from the throw controller.
- `throw_en`  out  1: drives the throw controller `enable`.
- `throw_force`  out  10: latched force, stable while `throw_en`=1.
- `wind_force`  out  7: 0..100; 50 means calm.
- `force_level`  out  10: live meter value for the HUD.
- `charging`  out  1: high in CHARGE.
- `turn_done`  out  1: one-cycle pulse when the throw completes.

## Operation
- `btn` passes through a 2-flop synchronizer to give `btn_s`. `btn_s_d` is `btn_s` delayed one cycle. A press is `btn_s & ~btn_s_d`.
- Tick counter runs 0..`TICK_DIV`-1 and `tick` is asserted at the terminal count. The counter clears to 0 in the cycle CHARGE is entered.
- States: IDLE, CHARGE, THROW.
  - **IDLE.** `throw_en`=0, `charging`=0, `force_level`=0. When `turn_en` and a press occur together, go to CHARGE with direction up.
  - **CHARGE.** `charging`=1. On `tick`:
    - Up: if `force_level`+`FORCE_STEP` >= `FORCE_MAX`, set it to `FORCE_MAX` and flip direction to down. Otherwise add `FORCE_STEP`.
    - Down: if `force_level` <= `FORCE_STEP`, set it to 0 and flip direction to up. Otherwise subtract `FORCE_STEP`.
    - Arithmetic is unsigned, computed 11 bits wide, so there is no wrap.
  - **CHARGE exits.**
    - `btn_s`=0: `throw_force` <= max(`force_level`, `MIN_FORCE`), `throw_en` <= 1, go to THROW.
    - `turn_en`=0: abort to IDLE. `throw_force` is unchanged and `throw_en` stays 0.
    - Release and `turn_en` drop in the same cycle: the abort wins.
  - **THROW.** `throw_en`=1 and `force_level` holds. Button activity is ignored. When `throw_done`=1: `throw_en` <= 0, `turn_done` pulses for one cycle, wind updates, go to IDLE. `turn_en` dropping in THROW does not abort the throw.
- After IDLE is re-entered, a new charge needs a fresh press edge. A button still held does not restart charging.

## Timing
- Reset values: `throw_en`=0, `throw_force`=0, `force_level`=0, `wind_force`=50, `charging`=0, `turn_done`=0, state IDLE, direction up, LFSR=16'hACE1.
- Press to CHARGE: 3 cycles after the `btn` rising edge (2 sync + 1 edge register).
- First meter step: `TICK_DIV` cycles after CHARGE entry.
- Release to `throw_en`=1: 3 cycles after the `btn` falling edge. `throw_force` is valid in the same cycle as `throw_en`.
- `throw_done`=1 to `throw_en`=0: 1 cycle. `turn_done` is high in that same cycle. `wind_force` is updated in that same cycle.
- Asynchronous reset mid-THROW drops `throw_en` immediately. The downstream controller sees `enable` low.

## Configuration
- `THROW_WIND_RANDOM_EN` defined:
  - A 16-bit Galois LFSR (taps 0xB400) advances every clock.
  - On each `turn_done`, let `r` = `lfsr[6:0]`. Then `wind_force` <= (`r` > 100) ? `r`-27 : `r`.
- Not defined: no LFSR is instantiated and `wind_force` is constant 50.

## Test plan
- **Basic ramp.** `TICK_DIV`=4, `FORCE_STEP`=16, `turn_en`=1. Hold `btn` for 3+5×4 cycles, then release. Expect `throw_en`=1 with `throw_force`=80, and `charging`=0.
- **Ping-pong.** `FORCE_STEP`=300, hold `btn` for 6 ticks. Expect `force_level` sequence 300, 600, 900, 1023, 723, 423.
- **Minimum force.** Release before the first tick. Expect `throw_force`=64.
- **Abort.** Drop `turn_en` mid-CHARGE at `force_level`=48. Expect IDLE, `force_level`=0, `throw_en` never asserted. Keep `btn` held and raise `turn_en` again: no charge until `btn` is released and pressed again.
- **Completion handshake.**
  - In THROW, toggle `btn`: no effect.
  - Assert `throw_done`: next cycle `throw_en`=0 and `turn_done`=1 for exactly one cycle.
  - With `THROW_WIND_RANDOM_EN`, `wind_force` is <= 100. Without it, `wind_force`=50.
- **Reset.** Assert `rst_n`=0 asynchronously in THROW. `throw_en`, `throw_force` and `force_level` go to 0 without a clock edge, and `wind_force` goes to 50.
